// File: rtl/piece_mover.sv
// piece_mover: moves the active piece under gravity and player input, flags when it can no longer descend
module piece_mover #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int DROP_TICKS = 50
) (
  input  logic                 clka,
  input  logic                 restart_n,
  input  logic                 start_move,
  input  logic [15:0]          piece_shape,
  input  logic [4:0]           spawn_row,
  input  logic [4:0]           spawn_col,
  input  logic [ROWS*COLS-1:0] board_occ,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_down,
  output logic [4:0]           piece_row,
  output logic [4:0]           piece_col,
  output logic                 moving,
  output logic                 touched
);
  localparam int TW = $clog2(DROP_TICKS);
  localparam int IW = $clog2(ROWS*COLS);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] shape;
  logic [TW-1:0] timer;
  logic [15:0] bad_d, bad_l, bad_r;
  logic signed [5:0] row_s, col_s;
  logic tick, drop, go_left, go_right, fit_down, fit_left, fit_right;

  // out-of-board cells are blocked before the board index is ever trusted
  function automatic logic cell_bad(input logic [ROWS*COLS-1:0] occ, input int rr, input int cc);
    return cc < 0 || cc >= COLS || rr < 0 || rr >= ROWS || occ[IW'(rr*COLS+cc)];
  endfunction

  assign row_s = $signed({1'b0, piece_row});
  assign col_s = $signed({piece_col[4], piece_col});

  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      assign bad_d[4*i+j] = shape[4*i+j] & cell_bad(board_occ, int'(row_s) + 1 + i, int'(col_s) + j);
      assign bad_l[4*i+j] = shape[4*i+j] & cell_bad(board_occ, int'(row_s) + i, int'(col_s) - 1 + j);
      assign bad_r[4*i+j] = shape[4*i+j] & cell_bad(board_occ, int'(row_s) + i, int'(col_s) + 1 + j);
    end
  end

  assign fit_down  = ~|bad_d && (int'(row_s) + 1 < ROWS);
  assign fit_left  = ~|bad_l;
  assign fit_right = ~|bad_r;
  assign tick      = timer == TW'(DROP_TICKS - 1);
  assign drop      = tick | btn_down;
  assign go_left   = btn_left & ~btn_right & ~drop;
  assign go_right  = btn_right & ~btn_left & ~drop;

  always_ff @(posedge clka or negedge restart_n)
    if (!restart_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_move ? LOAD : IDLE;
      LOAD:    state_nx = ACTIVE;
      ACTIVE:  state_nx = !start_move ? IDLE : (drop && !fit_down) ? DONE : ACTIVE;
      DONE:    state_nx = start_move ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb moving = state == ACTIVE;

  always_ff @(posedge clka or negedge restart_n)
    if (!restart_n) begin
      shape     <= '0;
      piece_row <= '0;
      piece_col <= '0;
      timer     <= '0;
      touched   <= 1'b0;
    end else begin
      touched <= state == ACTIVE && start_move && drop && !fit_down;
      if (state == LOAD) begin
        shape     <= piece_shape;
        piece_row <= spawn_row;
        piece_col <= spawn_col;
        timer     <= '0;
      end else if (state == ACTIVE && start_move) begin
        timer <= drop ? '0 : timer + 1'b1;
        if (drop && fit_down) piece_row <= piece_row + 1'b1;
        if (go_left && fit_left) piece_col <= piece_col - 1'b1;
        if (go_right && fit_right) piece_col <= piece_col + 1'b1;
      end
    end
endmodule

// File: tb/tb_piece_mover.sv
// tb_piece_mover: directed stimulus against a cell-array reference model of the piece mover
module tb_piece_mover;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int DT   = 4;

  logic clka = 0, restart_n = 1, start_move = 0;
  logic btn_left = 0, btn_right = 0, btn_down = 0;
  logic [15:0] piece_shape = '0;
  logic [4:0] spawn_row = '0, spawn_col = '0;
  logic [ROWS*COLS-1:0] board_occ = '0;
  logic [4:0] piece_row, piece_col;
  logic moving, touched;
  int tests = 0, fails = 0;

  bit brd [ROWS][COLS];
  int m_ph, m_row, m_col, m_timer;
  bit m_touch;
  logic [15:0] m_shape;

  piece_mover #(.ROWS(ROWS), .COLS(COLS), .DROP_TICKS(DT)) dut (
    .clka(clka), .restart_n(restart_n), .start_move(start_move),
    .piece_shape(piece_shape), .spawn_row(spawn_row), .spawn_col(spawn_col),
    .board_occ(board_occ), .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .piece_row(piece_row), .piece_col(piece_col), .moving(moving), .touched(touched)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit m_fits(input int r, input int c);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (m_shape[4*i+j]) begin
          int rr, cc;
          rr = r + i;
          cc = c + j;
          if (cc < 0 || cc >= COLS || rr >= ROWS || brd[rr][cc]) return 0;
        end
    return 1;
  endfunction

  // phase: 0 idle, 1 loading, 2 active, 3 done
  always @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      m_ph = 0; m_row = 0; m_col = 0; m_timer = 0; m_touch = 0; m_shape = '0;
    end else begin
      m_touch = 0;
      if (m_ph == 0) begin
        if (start_move) m_ph = 1;
      end else if (m_ph == 1) begin
        m_shape = piece_shape;
        m_row = int'(spawn_row);
        m_col = int'($signed(spawn_col));
        m_timer = 0;
        m_ph = 2;
      end else if (m_ph == 2) begin
        if (!start_move) m_ph = 0;
        else if (m_timer == DT - 1 || btn_down) begin
          if (m_fits(m_row + 1, m_col)) begin
            m_row++;
            m_timer = 0;
          end else begin
            m_touch = 1;
            m_ph = 3;
          end
        end else begin
          int d;
          m_timer++;
          d = btn_left ? -1 : 1;
          if (btn_left != btn_right && m_fits(m_row, m_col + d)) m_col += d;
        end
      end else if (!start_move) m_ph = 0;
    end
  end

  always @(negedge clka) begin
    chk("row", int'(piece_row), m_row);
    chk("col", int'($signed(piece_col)), m_col);
    chk("moving", int'(moving), int'(m_ph == 2));
    chk("touched", int'(touched), int'(m_touch));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic launch(input logic [15:0] sh, input int r, input int c);
    start_move = 0;
    cyc(1);
    piece_shape = sh;
    spawn_row = 5'(r);
    spawn_col = 5'(c);
    start_move = 1;
    cyc(2);
  endtask

  task automatic wait_touch(input string name);
    int ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(1);
      if (touched) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  task automatic set_row(input int r, input bit v);
    for (int c = 0; c < COLS; c++) begin
      brd[r][c] = v;
      board_occ[r*COLS+c] = v;
    end
  endtask

  initial begin
    #1 restart_n = 0;
    #1;
    chk("rst_row", int'(piece_row), 0);
    chk("rst_moving", int'(moving), 0);
    cyc(1);
    restart_n = 1;

    // asynchronous reset while active
    launch(16'h000F, 0, 3);
    chk("t1_active", int'(moving), 1);
    cyc(2);
    #2 restart_n = 0;
    #1;
    chk("t1_async_row", int'(piece_row), 0);
    chk("t1_async_col", int'(piece_col), 0);
    chk("t1_async_moving", int'(moving), 0);
    chk("t1_async_touched", int'(touched), 0);
    cyc(1);
    restart_n = 1;
    cyc(1);
    chk("t1_load_not_moving", int'(moving), 0);
    cyc(1);
    chk("t1_reactive", int'(moving), 1);

    // gravity down an empty board
    launch(16'h000F, 0, 3);
    chk("t2_spawn_row", int'(piece_row), 0);
    chk("t2_spawn_col", int'($signed(piece_col)), 3);
    cyc(3);
    chk("t2_before_tick", int'(piece_row), 0);
    cyc(1);
    chk("t2_after_tick", int'(piece_row), 1);
    wait_touch("t2_touch_seen");
    chk("t2_floor_row", int'(piece_row), 19);
    cyc(1);
    chk("t2_touch_pulse", int'(touched), 0);
    chk("t2_done_moving", int'(moving), 0);
    chk("t2_held_row", int'(piece_row), 19);

    // walls
    launch(16'h000F, 0, 6);
    btn_right = 1;
    cyc(1);
    btn_right = 0;
    chk("t3_right_wall", int'($signed(piece_col)), 6);
    for (int k = 1; k <= 10; k++) begin
      btn_left = (k % 4 != 3);
      cyc(1);
    end
    btn_left = 0;
    chk("t3_left_wall", int'($signed(piece_col)), 0);
    chk("t3_row", int'(piece_row), 2);

    // landing on a full row
    set_row(10, 1);
    launch(16'h0033, 0, 4);
    wait_touch("t4_touch_seen");
    chk("t4_land_row", int'(piece_row), 8);
    chk("t4_land_col", int'($signed(piece_col)), 4);
    cyc(1);
    chk("t4_touch_once", int'(touched), 0);
    cyc(2);
    chk("t4_still_quiet", int'(touched), 0);

    // arbitration
    set_row(10, 0);
    launch(16'h0033, 5, 4);
    btn_down = 1;
    btn_left = 1;
    cyc(1);
    chk("t5_drop_wins_row", int'(piece_row), 6);
    chk("t5_drop_wins_col", int'($signed(piece_col)), 4);
    btn_down = 0;
    btn_right = 1;
    cyc(1);
    btn_right = 0;
    chk("t5_lr_row", int'(piece_row), 6);
    chk("t5_lr_col", int'($signed(piece_col)), 4);
    cyc(1);
    btn_left = 0;
    chk("t5_left_col", int'($signed(piece_col)), 3);

    // abort
    launch(16'h0033, 7, 4);
    start_move = 0;
    btn_down = 1;
    cyc(1);
    btn_down = 0;
    chk("t6_row", int'(piece_row), 7);
    chk("t6_moving", int'(moving), 0);
    chk("t6_touched", int'(touched), 0);
    cyc(2);
    chk("t6_held_row", int'(piece_row), 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
